fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: two-requester burst arbiter in front of a FIFO write port.
//
// A requester is granted for one burst at a time. The burst ends on an
// accepted beat carrying last, or when MAX_BURST beats have been accepted
// (forced release, flagged by a one-cycle trunc pulse). Each release passes
// round-robin priority to the other requester and returns through one IDLE
// cycle before the next grant.
//
// Ports:
//   w_clk, rst_n          clock, asynchronous active-low reset
//   req0/1, last0/1       requester beat valid / final beat of burst
//   data0/1  [DW-1:0]     requester beat data
//   ack0/1                beat accepted this cycle (combinational)
//   w_full                FIFO full flag
//   w_en, w_data          FIFO write enable / data (combinational)
//   gnt      [1:0]        one-hot grant, 2'b00 when idle
//   beat_cnt [3:0]        beats accepted in the current grant
//   trunc                 pulse after a forced release at MAX_BURST
//
// state | meaning
// IDLE  | no grant; arbitrate on req0/req1 using rr
// GNT0  | requester 0 owns the FIFO write port
// GNT1  | requester 1 owns the FIFO write port
module fifo_wr_arb #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 8
) (
    input  logic          w_clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          last0,
    input  logic          last1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic          ack0,
    output logic          ack1,
    input  logic          w_full,
    output logic          w_en,
    output logic [DW-1:0] w_data,
    output logic [1:0]    gnt,
    output logic [3:0]    beat_cnt,
    output logic          trunc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic [3:0] cnt_d;
    logic       trunc_d;
    logic       last_sel;
    logic       at_max;
    logic [3:0] cnt_inc;

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            beat_cnt <= 4'd0;
            trunc    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            beat_cnt <= cnt_d;
            trunc    <= trunc_d;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = beat_cnt;
        trunc_d  = 1'b0;
        cnt_inc  = beat_cnt + 4'd1;
        at_max   = (cnt_inc == MAX_B);

        case (state_q)
            GNT0:    gnt = 2'b01;
            GNT1:    gnt = 2'b10;
            default: gnt = 2'b00;
        endcase

        ack0     = gnt[0] & req0 & ~w_full;
        ack1     = gnt[1] & req1 & ~w_full;
        w_en     = ack0 | ack1;
        w_data   = gnt[1] ? data1 : data0;
        last_sel = gnt[1] ? last1 : last0;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (req0 && req1) begin
                    state_d = rr_q ? GNT1 : GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (w_en) begin
                    if (last_sel || at_max) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        rr_d    = (state_q == GNT0);
                        // last wins over the burst limit: no trunc when both hit
                        trunc_d = ~last_sel;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
